// File: rtl/uart_rx_block_packer.sv
// Packs 2**ADDR_SPACE_EXP received UART bytes (byte 0 in the LSBs) into one cipher block.
// The block is held until the consumer reads it; partial blocks are dropped after an idle timeout.
module uart_rx_block_packer #(
  parameter int unsigned DATA_SIZE      = 8,
  parameter int unsigned ADDR_SPACE_EXP = 3,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                                      clk_100MHz,
  input  logic                                      reset,
  input  logic [DATA_SIZE-1:0]                      rx_data_in,
  input  logic                                      rx_done_tick,
  input  logic                                      block_read,
  output logic [DATA_SIZE*(2**ADDR_SPACE_EXP)-1:0]  block_data_out,
  output logic                                      block_ready,
  output logic [ADDR_SPACE_EXP:0]                   byte_count,
  output logic                                      overrun,
  output logic                                      timeout_err
);

  localparam int unsigned N  = 2**ADDR_SPACE_EXP;
  localparam int unsigned BW = DATA_SIZE * N;
  localparam int unsigned AW = (ADDR_SPACE_EXP > 0) ? ADDR_SPACE_EXP : 1;
  localparam int unsigned CW = ADDR_SPACE_EXP + 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FULL    = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [BW-1:0]   blk_d;
  logic [CW-1:0]   cnt_d;
  logic            ready_d;
  logic            ovr_d;
  logic            tout_d;

  logic [AW-1:0]   wr_idx_c;
  logic            accept_c;
  logic            last_word_c;
  logic            timeout_hit_c;

  // A tick is taken unless a block is pending and not being read in the same cycle.
  assign accept_c      = rx_done_tick && ((state_q != FULL) || block_read);
  assign wr_idx_c      = (state_q == COLLECT) ? byte_count[AW-1:0] : '0;
  assign last_word_c   = (wr_idx_c == AW'(N - 1));
  assign timeout_hit_c = (state_q == COLLECT) && !rx_done_tick &&
                         (timer_q == TW'(TIMEOUT_CYCLES - 1));

  // State register
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (accept_c)                             state_d = last_word_c ? FULL : COLLECT;
    else if ((state_q == FULL) && block_read) state_d = IDLE;
    else if (timeout_hit_c)                   state_d = IDLE;
  end

  // Next values of the registered datapath and outputs
  always_comb begin
    blk_d   = block_data_out;
    cnt_d   = byte_count;
    timer_d = timer_q;
    ready_d = block_ready;
    ovr_d   = overrun;
    tout_d  = 1'b0;
    if (accept_c) begin
      // A new block starts from a clean slate so stale bytes never leak into it.
      if (state_q != COLLECT) blk_d = '0;
      blk_d[DATA_SIZE * 32'(wr_idx_c) +: DATA_SIZE] = rx_data_in;
      cnt_d   = CW'(wr_idx_c) + CW'(1);
      timer_d = '0;
      ready_d = last_word_c;
    end else if (state_q == FULL) begin
      timer_d = '0;
      if (block_read) begin
        ready_d = 1'b0;
        cnt_d   = '0;
      end else if (rx_done_tick) begin
        ovr_d = 1'b1;
      end
    end else if (timeout_hit_c) begin
      blk_d   = '0;
      cnt_d   = '0;
      timer_d = '0;
      tout_d  = 1'b1;
    end else if (state_q == COLLECT) begin
      timer_d = timer_q + TW'(1);
    end
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      block_data_out <= '0;
      byte_count     <= '0;
      timer_q        <= '0;
      block_ready    <= 1'b0;
      overrun        <= 1'b0;
      timeout_err    <= 1'b0;
    end else begin
      block_data_out <= blk_d;
      byte_count     <= cnt_d;
      timer_q        <= timer_d;
      block_ready    <= ready_d;
      overrun        <= ovr_d;
      timeout_err    <= tout_d;
    end
  end

endmodule
